// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit layout, default packet sizing and the
// injection arbiter state encoding.
package noc_pkg;
  localparam int FLIT_W        = 17;
  localparam int VALID_BIT     = 16;
  localparam int DST_HI        = 15;
  localparam int DST_LO        = 12;
  localparam int SRC_HI        = 11;
  localparam int SRC_LO        = 8;
  localparam int DATA_HI       = 7;
  localparam int DATA_LO       = 0;
  localparam int PKT_LEN_DEF   = 4;
  localparam int STALL_MAX_DEF = 15;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic       vld;
    logic [3:0] dst;
    logic [3:0] src;
    logic [7:0] data;
  } flit_t;
endpackage

// File: rtl/rr_pick.sv
// Round-robin priority finder: the first asserted request after i_last
// (modulo N) wins; i_last itself has the lowest priority.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);
  int           w_c;
  logic [N-1:0] w_sh;

  always_comb begin
    o_idx = i_last;
    o_any = |i_req;
    w_c   = 0;
    w_sh  = '0;
    // walk farthest-to-nearest so the nearest requester overrides
    for (int k = N; k >= 1; k--) begin
      w_c  = (int'(i_last) + k) % N;
      w_sh = i_req >> w_c;
      if (w_sh[0]) o_idx = IW'(w_c);
    end
  end
endmodule

// File: rtl/noc_inject_arbiter.sv
// Packet-granular round-robin arbiter sharing one router injection port,
// with a watchdog that aborts a packet whose owner stops sending flits.
module noc_inject_arbiter #(
  parameter  int N_REQ     = 4,
  parameter  int FLIT_W    = noc_pkg::FLIT_W,
  parameter  int PKT_LEN   = noc_pkg::PKT_LEN_DEF,
  parameter  int STALL_MAX = noc_pkg::STALL_MAX_DEF,
  localparam int GW        = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*FLIT_W-1:0] req_flit,
  output logic [N_REQ-1:0]        req_ready,
  input  logic                    out_ready,
  output logic [FLIT_W-1:0]       out_flit,
  output logic [GW-1:0]           grant_id,
  output logic                    busy,
  output logic                    abort_pulse
);
  import noc_pkg::*;

  localparam int BW = $clog2(PKT_LEN + 1);
  localparam int SW = $clog2(STALL_MAX + 1);
  localparam logic [BW-1:0] LAST_BEAT  = BW'(PKT_LEN - 1);
  localparam logic [SW-1:0] STALL_TRIP = SW'(STALL_MAX - 1);
  localparam logic [SW-1:0] STALL_SAT  = SW'(STALL_MAX);

  arb_state_e                   r_state, w_state_nxt;
  logic [GW-1:0]                r_grant, w_grant_nxt;
  logic [BW-1:0]                r_beat, w_beat_nxt;
  logic [SW-1:0]                r_stall, w_stall_nxt;
  logic [FLIT_W-1:0]            r_out, w_out_nxt;
  logic                         r_abort, w_abort_nxt;
  logic [N_REQ-1:0][FLIT_W-1:0] w_flits;
  logic [GW-1:0]                w_pick;
  logic                         w_any;
  logic                         w_gvld;
  logic                         w_xfer;

  assign w_flits = req_flit;
  assign w_gvld  = req_valid[r_grant];
  assign w_xfer  = (r_state == SEND) && w_gvld && out_ready;

  rr_pick #(.N(N_REQ), .IW(GW)) u_pick (
    .i_req  (req_valid),
    .i_last (r_grant),
    .o_idx  (w_pick),
    .o_any  (w_any)
  );

  // Only the owner of the current packet is ever acknowledged.
  for (genvar i = 0; i < N_REQ; i++) begin : g_rdy
    assign req_ready[i] = (r_state == SEND) && (r_grant == GW'(i)) &&
                          req_valid[i] && out_ready;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_beat_nxt  = r_beat;
    w_stall_nxt = r_stall;
    w_out_nxt   = '0;
    w_abort_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_grant_nxt = w_pick;
          w_beat_nxt  = '0;
          w_stall_nxt = '0;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        if (w_xfer) begin
          w_out_nxt             = w_flits[r_grant];
          w_out_nxt[FLIT_W-1]   = 1'b1;
          w_beat_nxt            = r_beat + BW'(1);
          w_stall_nxt           = '0;
          if (r_beat == LAST_BEAT) begin
            w_beat_nxt  = '0;
            w_state_nxt = IDLE;
          end
        end else if (!w_gvld) begin
          // the cycle that would bring the count to STALL_MAX aborts instead
          if (r_stall >= STALL_TRIP) begin
            w_state_nxt = IDLE;
            w_beat_nxt  = '0;
            w_stall_nxt = '0;
            w_abort_nxt = 1'b1;
          end else if (r_stall != STALL_SAT) begin
            w_stall_nxt = r_stall + SW'(1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_grant <= GW'(N_REQ - 1);
      r_beat  <= '0;
      r_stall <= '0;
      r_out   <= '0;
      r_abort <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_beat  <= w_beat_nxt;
      r_stall <= w_stall_nxt;
      r_out   <= w_out_nxt;
      r_abort <= w_abort_nxt;
    end
  end

  assign out_flit    = r_out;
  assign grant_id    = r_grant;
  assign busy        = (r_state == SEND);
  assign abort_pulse = r_abort;
endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Bench for noc_inject_arbiter: requester models feed a scoreboard of
// forwarded flits; arbitration order is table-driven, corner cases hand-written.
module tb_noc_inject_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int FW = 17;
  localparam int TW = N * FW;
  localparam int PL = 4;
  localparam int SM = 15;

  logic          clk       = 1'b0;
  logic          rst       = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [TW-1:0] req_flit  = '0;
  logic [N-1:0]  req_ready;
  logic          out_ready = 1'b1;
  logic [FW-1:0] out_flit;
  logic [IW-1:0] grant_id;
  logic          busy;
  logic          abort_pulse;

  noc_inject_arbiter #(.N_REQ(N), .FLIT_W(FW), .PKT_LEN(PL), .STALL_MAX(SM)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_flit(req_flit),
    .req_ready(req_ready), .out_ready(out_ready), .out_flit(out_flit),
    .grant_id(grant_id), .busy(busy), .abort_pulse(abort_pulse)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [FW-1:0] f; } olog_t;
  typedef struct { logic [N-1:0] mask; int exp_g; } vec_t;

  int            checks = 0, errors = 0, cyc = 0, n_abort = 0, o_cnt = 0, o_src = 0;
  int            npkt[N], beat[N], pktn[N];
  bit            hold[N];
  logic [FW-1:0] exp_q[$];
  olog_t         olog[$];
  int            porder[$];
  logic [N-1:0]  rdy_s;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [FW-1:0] mk_flit(input int i);
    logic [FW-1:0] f;
    f        = '0;
    f[15:12] = 4'(pktn[IW'(i)] + 1);
    f[11:8]  = 4'(i);
    f[7:0]   = 8'(8'hAA + 8'h11 * beat[IW'(i)]);
    return f;
  endfunction

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (npkt[IW'(i)] > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive();
    logic [TW-1:0] fl;
    logic [N-1:0]  v;
    fl = '0;
    v  = '0;
    for (int i = 0; i < N; i++) begin
      if (npkt[IW'(i)] > 0 && !hold[IW'(i)]) v = v | (N'(1) << i);
      fl = fl | (TW'(mk_flit(i)) << (i * FW));
    end
    req_valid = v;
    req_flit  = fl;
  endtask

  // One clock: drive at negedge, note what will be consumed, compare at next negedge.
  task automatic tick();
    logic [FW-1:0] e;
    drive();
    #3;
    rdy_s = req_ready;
    chk("ready_onehot", 32'($onehot0(rdy_s)), 1);
    chk("ready_without_valid", 32'(rdy_s & ~req_valid), 0);
    for (int i = 0; i < N; i++) begin
      if (rdy_s[IW'(i)]) begin
        e = mk_flit(i);
        e[FW-1] = 1'b1;
        exp_q.push_back(e);
      end
    end
    @(negedge clk);
    cyc++;
    if (out_flit != '0) begin
      olog.push_back('{cyc, out_flit});
      if (exp_q.size() == 0) chk("unexpected_flit", 32'(out_flit), 0);
      else begin
        e = exp_q.pop_front();
        chk("sb_flit", 32'(out_flit), 32'(e));
      end
      if (o_cnt == 0) o_src = int'(out_flit[11:8]);
      else chk("no_interleave", 32'(out_flit[11:8]), 32'(o_src));
      o_cnt++;
      if (o_cnt == PL) begin
        porder.push_back(o_src);
        o_cnt = 0;
      end
    end else if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("sb_missing", 32'(out_flit), 32'(e));
    end
    if (abort_pulse) begin
      n_abort++;
      o_cnt = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (rdy_s[IW'(i)]) begin
        beat[IW'(i)]++;
        if (beat[IW'(i)] == PL) begin
          beat[IW'(i)] = 0;
          pktn[IW'(i)]++;
          npkt[IW'(i)]--;
        end
      end
    end
  endtask

  task automatic clr_models();
    for (int i = 0; i < N; i++) begin
      npkt[IW'(i)] = 0; beat[IW'(i)] = 0; pktn[IW'(i)] = 0; hold[IW'(i)] = 1'b0;
    end
    exp_q.delete();
    o_cnt = 0;
  endtask

  task automatic clr_logs();
    olog.delete();
    porder.delete();
    n_abort = 0;
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    out_ready = 1'b1;
    clr_models();
    drive();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic drain(input string nm, input int bound);
    int k;
    k = 0;
    while (pending() && k < bound) begin
      tick();
      k++;
    end
    chk({nm, "_done"}, 32'(pending()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    vec_t vv;
    logic [N-1:0] m;
    int t0, k;
    tbl.push_back('{4'b1111, 1});
    tbl.push_back('{4'b1111, 2});
    tbl.push_back('{4'b0011, 0});
    tbl.push_back('{4'b1010, 1});
    tbl.push_back('{4'b0100, 2});
    tbl.push_back('{4'b1101, 3});
    tbl.push_back('{4'b1000, 3});
    tbl.push_back('{4'b0110, 1});

    // reset state
    do_reset();
    chk("rst_out_flit", 32'(out_flit), 0);
    chk("rst_grant", 32'(grant_id), 3);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_abort", 32'(abort_pulse), 0);
    chk("rst_ready", 32'(req_ready), 0);
    repeat (3) tick();
    chk("idle_stays", 32'(busy), 0);

    // single requester 1: AA..DD starting two cycles after valid
    clr_logs();
    t0 = cyc;
    npkt[1] = 1;
    tick();
    chk("idle_no_consume", 32'(rdy_s), 0);
    chk("t1_grant", 32'(grant_id), 1);
    chk("t1_busy", 32'(busy), 1);
    drain("t1", 20);
    tick();
    chk("t1_tail_zero", 32'(out_flit), 0);
    chk("t1_count", 32'(olog.size()), 4);
    if (olog.size() == 4) begin
      chk("t1_flit0", 32'(olog[0].f), 32'h111AA);
      for (int i = 0; i < 4; i++) begin
        chk("t1_data", 32'(olog[i].f[7:0]), 32'(8'hAA + 8'h11 * i));
        chk("t1_cycle", 32'(olog[i].cyc), 32'(t0 + 2 + i));
      end
    end

    // all four continuously valid: order 0,1,2,3,0 with one idle cycle between
    do_reset();
    clr_logs();
    npkt[0] = 2; npkt[1] = 1; npkt[2] = 1; npkt[3] = 1;
    drain("t2", 60);
    tick();
    chk("t2_pkts", 32'(porder.size()), 5);
    if (porder.size() == 5) begin
      chk("t2_ord0", 32'(porder[0]), 0);
      chk("t2_ord1", 32'(porder[1]), 1);
      chk("t2_ord2", 32'(porder[2]), 2);
      chk("t2_ord3", 32'(porder[3]), 3);
      chk("t2_ord4", 32'(porder[4]), 0);
    end
    if (olog.size() == 20)
      for (int i = 0; i < 20; i++)
        chk("t2_gap", 32'(olog[i].cyc), 32'(olog[0].cyc + i + i / 4));
    chk("t2_no_abort", 32'(n_abort), 0);

    // table-driven round-robin picks from the running grant pointer
    for (int j = 0; j < tbl.size(); j++) begin
      vv = tbl[j];
      clr_logs();
      for (int i = 0; i < N; i++) begin
        m = vv.mask >> i;
        npkt[IW'(i)] = m[0] ? 1 : 0;
      end
      tick();
      chk("tbl_grant", 32'(grant_id), 32'(vv.exp_g));
      chk("tbl_busy", 32'(busy), 1);
      k = 0;
      while (npkt[IW'(vv.exp_g)] > 0 && k < 20) begin
        tick();
        k++;
      end
      chk("tbl_timeout", 32'(k < 20), 1);
      for (int i = 0; i < N; i++) npkt[IW'(i)] = 0;
      tick(); tick();
      chk("tbl_src", (porder.size() > 0) ? 32'(porder[0]) : 32'hFFFF_FFFF, 32'(vv.exp_g));
      chk("tbl_one_pkt", 32'(porder.size()), 1);
    end

    // router backpressure: holds, never stalls the watchdog
    clr_models();
    clr_logs();
    npkt[0] = 1;
    tick();
    chk("bp_grant", 32'(grant_id), 0);
    tick();
    out_ready = 1'b0;
    tick();
    chk("bp_rdy_a", 32'(rdy_s), 0);
    chk("bp_gap_a", 32'(out_flit), 0);
    tick();
    chk("bp_rdy_b", 32'(rdy_s), 0);
    chk("bp_gap_b", 32'(out_flit), 0);
    out_ready = 1'b1;
    tick();
    chk("bp_resume", 32'(rdy_s), 32'h1);
    out_ready = 1'b0;
    repeat (20) begin
      tick();
      chk("bp_long_rdy", 32'(rdy_s), 0);
    end
    chk("bp_still_busy", 32'(busy), 1);
    out_ready = 1'b1;
    drain("bp", 20);
    tick();
    chk("bp_count", 32'(olog.size()), 4);
    chk("bp_no_abort", 32'(n_abort), 0);
    if (olog.size() == 4)
      for (int i = 0; i < 4; i++)
        chk("bp_data", 32'(olog[i].f[7:0]), 32'(8'hAA + 8'h11 * i));

    // watchdog: requester 2 stalls after two flits, requester 3 waits
    do_reset();
    clr_logs();
    npkt[2] = 1; npkt[3] = 1;
    tick();
    chk("st_grant", 32'(grant_id), 2);
    tick(); tick();
    chk("st_beats", 32'(beat[2]), 2);
    hold[2] = 1'b1;
    for (int s = 1; s <= SM; s++) begin
      tick();
      if (s < SM) begin
        chk("st_no_abort_yet", 32'(abort_pulse), 0);
        chk("st_busy", 32'(busy), 1);
      end else begin
        chk("st_abort", 32'(abort_pulse), 1);
        chk("st_idle", 32'(busy), 0);
      end
    end
    npkt[2] = 0; beat[2] = 0; hold[2] = 1'b0;
    tick();
    chk("st_pulse_1cyc", 32'(abort_pulse), 0);
    chk("st_next_grant", 32'(grant_id), 3);
    chk("st_next_busy", 32'(busy), 1);
    drain("st", 20);
    tick();
    chk("st_abort_cnt", 32'(n_abort), 1);
    chk("st_pkts", 32'(porder.size()), 1);
    if (porder.size() == 1) chk("st_src", 32'(porder[0]), 3);

    // asynchronous reset mid-packet
    do_reset();
    clr_logs();
    npkt[1] = 1;
    repeat (3) tick();
    chk("mr_flit2", 32'(out_flit[7:0]), 32'hBB);
    drive();
    #2;
    rst = 1'b0;
    #1;
    chk("mr_out_zero", 32'(out_flit), 0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_grant", 32'(grant_id), 3);
    chk("mr_ready", 32'(req_ready), 0);
    clr_models();
    @(negedge clk);
    rst = 1'b1;
    chk("mr_grant_rel", 32'(grant_id), 3);
    clr_logs();
    for (int i = 0; i < N; i++) npkt[IW'(i)] = 1;
    tick();
    chk("mr_first", 32'(grant_id), 0);
    drain("mr", 40);
    tick();
    chk("mr_pkts", 32'(porder.size()), 4);
    if (porder.size() == 4)
      for (int i = 0; i < 4; i++) chk("mr_order", 32'(porder[i]), 32'(i));

    // requester 0 re-asserts right away; waiting requester 3 goes first
    do_reset();
    clr_logs();
    npkt[0] = 2; npkt[3] = 1;
    drain("sv", 40);
    tick();
    chk("sv_pkts", 32'(porder.size()), 3);
    if (porder.size() == 3) begin
      chk("sv_ord0", 32'(porder[0]), 0);
      chk("sv_ord1", 32'(porder[1]), 3);
      chk("sv_ord2", 32'(porder[2]), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
